// File: rtl/alu_seq_ctrl_pkg.sv
// Shared opcode constants and FSM state encoding for alu_seq_ctrl.
// Imported by the ALU and by the sequencing controller.
package alu_seq_ctrl_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/ALU.sv
// Combinational ALU: add/sub/and/or, modulo 2^WIDTH.
// Ports: a_i, b_i operands; op_i opcode; y_o result.
module ALU
    import alu_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [1:0]       op_i,
    output logic [WIDTH-1:0] y_o
);

    always_comb begin
        y_o = '0;
        unique case (1'b1)
            (op_i == OP_ADD): y_o = a_i + b_i;
            (op_i == OP_SUB): y_o = a_i - b_i;
            (op_i == OP_AND): y_o = a_i & b_i;
            (op_i == OP_OR):  y_o = a_i | b_i;
            default:          y_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequenced ALU with accumulator: IDLE accepts, EXEC computes, DONE holds.
// Ports: clk, rst (sync, active-high); in_* request handshake and
// operands; out_* result handshake; acc accumulator; op_cnt result count.
module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_use_acc,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic [WIDTH-1:0] acc,
    output logic [7:0]       op_cnt
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_y;

    ALU #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a_i  (a_q),
        .b_i  (b_q),
        .op_i (op_q),
        .y_o  (alu_y)
    );

    // in_ready is gated by rst so upstream never sees a
    // ready while the block is being reset.
    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = data_q;
    assign out_zero  = zero_q;
    assign acc       = acc_q;
    assign op_cnt    = cnt_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        data_d  = data_q;
        zero_d  = zero_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (acc_clr) begin
                    acc_d = '0;
                end
                if (in_valid) begin
                    // A clear in the same cycle makes the
                    // accumulator operand read as zero.
                    if (in_use_acc) begin
                        a_d = acc_clr ? '0 : acc_q;
                    end else begin
                        a_d = in_a;
                    end
                    b_d     = in_b;
                    op_d    = in_op;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                data_d  = alu_y;
                zero_d  = (alu_y == '0);
                acc_d   = alu_y;
                cnt_d   = cnt_q + 8'd1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            data_q  <= '0;
            zero_q  <= 1'b1;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
